// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared widths, opcodes and FSM encoding for the ALU sequencer
package alu_pkg;

  localparam int DATA_W  = 8;
  localparam int ADDR_W  = 6;
  localparam int INSTR_W = 16;

  localparam logic [2:0] OP_LDI = 3'd0;
  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_SUB = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_NOT = 3'd4;
  localparam logic [2:0] OP_OR  = 3'd5;
  localparam logic [2:0] OP_EQ  = 3'd6;
  localparam logic [2:0] OP_BR  = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_WAIT,
    ST_WB
  } state_t;

  // Only the arithmetic ops own the carry flag.
  function automatic logic op_sets_carry(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

  function automatic logic op_writes_reg(input logic [2:0] op);
    return op != OP_BR;
  endfunction

endpackage

// File: rtl/regfile4x8.sv
// rtl/regfile4x8.sv - 4x8 register file, two async read ports, debug port, one sync write
module regfile4x8
  import alu_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_we,
  input  logic [1:0]        i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [1:0]        i_raddr_a,
  input  logic [1:0]        i_raddr_b,
  input  logic [1:0]        i_dbg_sel,
  output logic [DATA_W-1:0] o_rdata_a,
  output logic [DATA_W-1:0] o_rdata_b,
  output logic [DATA_W-1:0] o_dbg_data
);

  logic [DATA_W-1:0] r_regs [4];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < 4; i++) r_regs[i] <= '0;
    end else if (i_we) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a  = r_regs[i_raddr_a];
  assign o_rdata_b  = r_regs[i_raddr_b];
  assign o_dbg_data = r_regs[i_dbg_sel];

endmodule

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - fetch/decode/execute/writeback controller driving a clocked 8-bit ALU
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int ALU_LAT = 1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        run,
  output logic        imem_req,
  output logic [5:0]  imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_data,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [5:0]  alu_addr,
  output logic [2:0]  alu_op,
  input  logic [7:0]  alu_result,
  input  logic        alu_co,
  input  logic        alu_eq,
  input  logic        alu_branch,
  output logic        carry,
  output logic        retired,
  input  logic [1:0]  dbg_sel,
  output logic [7:0]  dbg_data
);

  localparam logic [7:0] LP_WAIT_INIT = 8'(ALU_LAT - 1);

  state_t              r_state;
  logic [INSTR_W-1:0]  r_ir;
  logic [ADDR_W-1:0]   r_pc;
  logic                r_imem_req;
  logic [DATA_W-1:0]   r_alu_a;
  logic [DATA_W-1:0]   r_alu_b;
  logic [ADDR_W-1:0]   r_alu_addr;
  logic [2:0]          r_alu_op;
  logic                r_carry;
  logic                r_retired;
  logic [7:0]          r_wait_cnt;

  logic [2:0]          w_op;
  logic [1:0]          w_rd;
  logic [1:0]          w_rs;
  logic [1:0]          w_rt;
  logic [ADDR_W-1:0]   w_addr;
  logic [DATA_W-1:0]   w_imm;
  logic [DATA_W-1:0]   w_rs_data;
  logic [DATA_W-1:0]   w_rt_data;
  logic                w_we;
  logic [DATA_W-1:0]   w_wdata;
  logic                w_unused_eq;

  assign w_op   = r_ir[15:13];
  assign w_rd   = r_ir[12:11];
  assign w_rs   = r_ir[10:9];
  assign w_rt   = r_ir[8:7];
  assign w_addr = r_ir[5:0];
  assign w_imm  = r_ir[7:0];

  // The equal flag is already folded into alu_result for EQ.
  assign w_unused_eq = alu_eq;

  assign w_we    = (r_state == ST_WB) && op_writes_reg(w_op);
  assign w_wdata = (w_op == OP_LDI) ? w_imm : alu_result;

  regfile4x8 u_regfile (
    .i_clk      (CLK),
    .i_rst      (RST),
    .i_we       (w_we),
    .i_waddr    (w_rd),
    .i_wdata    (w_wdata),
    .i_raddr_a  (w_rs),
    .i_raddr_b  (w_rt),
    .i_dbg_sel  (dbg_sel),
    .o_rdata_a  (w_rs_data),
    .o_rdata_b  (w_rt_data),
    .o_dbg_data (dbg_data)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= ST_IDLE;
      r_ir       <= '0;
      r_pc       <= '0;
      r_imem_req <= 1'b0;
      r_alu_a    <= '0;
      r_alu_b    <= '0;
      r_alu_addr <= '0;
      r_alu_op   <= OP_LDI;
      r_carry    <= 1'b0;
      r_retired  <= 1'b0;
      r_wait_cnt <= '0;
    end else begin
      r_retired <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (run) begin
            r_imem_req <= 1'b1;
            r_state    <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (imem_ack) begin
            r_ir       <= imem_data;
            r_imem_req <= 1'b0;
            r_state    <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          // Operands are sampled here, so rd == rs sees the pre-writeback value.
          if (w_op == OP_LDI) begin
            r_state <= ST_WB;
          end else begin
            r_alu_a    <= w_rs_data;
            r_alu_b    <= w_rt_data;
            r_alu_op   <= w_op;
            r_alu_addr <= w_addr;
            r_state    <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          r_wait_cnt <= LP_WAIT_INIT;
          r_state    <= ST_WAIT;
        end
        ST_WAIT: begin
          if (r_wait_cnt == '0) begin
            r_alu_op <= OP_LDI;
            r_state  <= ST_WB;
          end else begin
            r_wait_cnt <= r_wait_cnt - 8'd1;
          end
        end
        ST_WB: begin
          if (op_sets_carry(w_op)) r_carry <= alu_co;
          if ((w_op == OP_BR) && alu_branch) r_pc <= w_addr;
          else                               r_pc <= r_pc + 6'd1;
          r_retired <= 1'b1;
          if (run) begin
            r_imem_req <= 1'b1;
            r_state    <= ST_FETCH;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_imem_req <= 1'b0;
          r_state    <= ST_IDLE;
        end
      endcase
    end
  end

  assign imem_req  = r_imem_req;
  assign imem_addr = r_pc;
  assign alu_a     = r_alu_a;
  assign alu_b     = r_alu_b;
  assign alu_addr  = r_alu_addr;
  assign alu_op    = r_alu_op;
  assign carry     = r_carry;
  assign retired   = r_retired;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - directed self-checking bench for alu_sequencer
module tb_alu_sequencer;

  logic        CLK = 1'b0;
  logic        RST;
  logic        run;
  logic        imem_req;
  logic [5:0]  imem_addr;
  logic        imem_ack;
  logic [15:0] imem_data;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [5:0]  alu_addr;
  logic [2:0]  alu_op;
  logic [7:0]  alu_result;
  logic        alu_co;
  logic        alu_eq;
  logic        alu_branch;
  logic        carry;
  logic        retired;
  logic [1:0]  dbg_sel;
  logic [7:0]  dbg_data;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 CLK = ~CLK;

  alu_sequencer #(.ALU_LAT(1)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .run        (run),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_data  (imem_data),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_addr   (alu_addr),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .alu_co     (alu_co),
    .alu_eq     (alu_eq),
    .alu_branch (alu_branch),
    .carry      (carry),
    .retired    (retired),
    .dbg_sel    (dbg_sel),
    .dbg_data   (dbg_data)
  );

  function automatic logic [15:0] enc(input logic [2:0] op, input logic [1:0] rd, rs, rt,
                                      input logic [5:0] addr);
    return {op, rd, rs, rt, 1'b0, addr};
  endfunction

  function automatic logic [15:0] ldi(input logic [1:0] rd, input logic [7:0] imm);
    return {3'd0, rd, 3'd0, imm};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic rd_chk(input string tag, input logic [1:0] sel, input logic [7:0] exp);
    dbg_sel = sel;
    #1;
    chk(tag, {8'h0, dbg_data}, {8'h0, exp});
  endtask

  // Waits (bounded) for a request, withholds ack for dly cycles, then acks once.
  task automatic do_fetch(input string tag, input logic [15:0] instr, input int dly,
                          input logic [5:0] exp_pc);
    int n = 0;
    while (!imem_req && n < 20) begin
      @(negedge CLK);
      n++;
    end
    chk({tag, "_req"}, {15'h0, imem_req}, 16'h1);
    chk({tag, "_pc"}, {10'h0, imem_addr}, {10'h0, exp_pc});
    for (int i = 0; i < dly; i++) begin
      imem_data = ldi(2'd3, 8'hEE);
      @(negedge CLK);
      chk({tag, "_req_hold"}, {15'h0, imem_req}, 16'h1);
    end
    imem_ack  = 1'b1;
    imem_data = instr;
    @(negedge CLK);
    imem_ack  = 1'b0;
    imem_data = 16'h0;
    chk({tag, "_req_drop"}, {15'h0, imem_req}, 16'h0);
  endtask

  task automatic finish_ldi(input string tag);
    @(negedge CLK);
    chk({tag, "_ret_early"}, {15'h0, retired}, 16'h0);
    @(negedge CLK);
    chk({tag, "_retired"}, {15'h0, retired}, 16'h1);
  endtask

  task automatic exec_alu(input string tag, input logic [7:0] ea, eb, input logic [2:0] eop,
                          input logic [5:0] eaddr, input logic [7:0] res,
                          input logic co, br);
    @(negedge CLK);
    chk({tag, "_a"}, {8'h0, alu_a}, {8'h0, ea});
    chk({tag, "_b"}, {8'h0, alu_b}, {8'h0, eb});
    chk({tag, "_op"}, {13'h0, alu_op}, {13'h0, eop});
    chk({tag, "_addr"}, {10'h0, alu_addr}, {10'h0, eaddr});
    alu_result = res;
    alu_co     = co;
    alu_branch = br;
    @(negedge CLK);
    chk({tag, "_op_hold"}, {13'h0, alu_op}, {13'h0, eop});
    @(negedge CLK);
    chk({tag, "_op_idle"}, {13'h0, alu_op}, 16'h0);
    chk({tag, "_ret_early"}, {15'h0, retired}, 16'h0);
    @(negedge CLK);
    chk({tag, "_retired"}, {15'h0, retired}, 16'h1);
  endtask

  initial begin
    RST = 1'b1; run = 1'b0; imem_ack = 1'b0; imem_data = 16'h0;
    alu_result = 8'h0; alu_co = 1'b0; alu_eq = 1'b0; alu_branch = 1'b0; dbg_sel = 2'd0;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    chk("rst_req", {15'h0, imem_req}, 16'h0);
    chk("rst_addr", {10'h0, imem_addr}, 16'h0);
    chk("rst_op", {13'h0, alu_op}, 16'h0);
    chk("rst_a", {8'h0, alu_a}, 16'h0);
    chk("rst_carry", {15'h0, carry}, 16'h0);
    chk("rst_retired", {15'h0, retired}, 16'h0);
    rd_chk("rst_r3", 2'd3, 8'h00);

    // Basic LDI/LDI/ADD.
    run = 1'b1;
    do_fetch("f0", ldi(2'd1, 8'h12), 0, 6'd0);
    finish_ldi("ldi_r1");
    chk("b2b_req", {15'h0, imem_req}, 16'h1);
    do_fetch("f1", ldi(2'd2, 8'h03), 0, 6'd1);
    finish_ldi("ldi_r2");
    do_fetch("f2", enc(3'd1, 2'd3, 2'd1, 2'd2, 6'd0), 0, 6'd2);
    exec_alu("add1", 8'h12, 8'h03, 3'd1, 6'd0, 8'h15, 1'b0, 1'b0);
    rd_chk("add1_r3", 2'd3, 8'h15);
    chk("add1_carry", {15'h0, carry}, 16'h0);

    // Carry out, then SUB clearing it.
    do_fetch("f3", ldi(2'd1, 8'hFF), 0, 6'd3);
    finish_ldi("ldi_ff1");
    do_fetch("f4", ldi(2'd2, 8'hFF), 0, 6'd4);
    finish_ldi("ldi_ff2");
    do_fetch("f5", enc(3'd1, 2'd3, 2'd1, 2'd2, 6'd0), 0, 6'd5);
    exec_alu("add2", 8'hFF, 8'hFF, 3'd1, 6'd0, 8'hFE, 1'b1, 1'b0);
    rd_chk("add2_r3", 2'd3, 8'hFE);
    chk("add2_carry", {15'h0, carry}, 16'h1);
    do_fetch("f6", enc(3'd2, 2'd0, 2'd1, 2'd2, 6'd0), 0, 6'd6);
    exec_alu("sub", 8'hFF, 8'hFF, 3'd2, 6'd0, 8'h00, 1'b0, 1'b0);
    rd_chk("sub_r0", 2'd0, 8'h00);
    chk("sub_carry", {15'h0, carry}, 16'h0);

    // EQ leaves carry alone; BR taken/not-taken; BR never writes rd.
    do_fetch("f7", enc(3'd6, 2'd3, 2'd1, 2'd1, 6'd0), 0, 6'd7);
    exec_alu("eq", 8'hFF, 8'hFF, 3'd6, 6'd0, 8'h01, 1'b1, 1'b0);
    rd_chk("eq_r3", 2'd3, 8'h01);
    chk("eq_carry", {15'h0, carry}, 16'h0);
    do_fetch("f8", enc(3'd7, 2'd3, 2'd1, 2'd2, 6'h24), 0, 6'd8);
    exec_alu("br_t", 8'hFF, 8'hFF, 3'd7, 6'h24, 8'hAA, 1'b0, 1'b1);
    chk("br_t_pc", {10'h0, imem_addr}, 16'h24);
    rd_chk("br_t_r3", 2'd3, 8'h01);
    do_fetch("f9", enc(3'd7, 2'd3, 2'd1, 2'd2, 6'h10), 0, 6'h24);
    exec_alu("br_n", 8'hFF, 8'hFF, 3'd7, 6'h10, 8'hAA, 1'b0, 1'b0);
    chk("br_n_pc", {10'h0, imem_addr}, 16'h25);

    // PC wrap from 63.
    do_fetch("f10", enc(3'd7, 2'd0, 2'd1, 2'd2, 6'h3F), 0, 6'h25);
    exec_alu("br_63", 8'hFF, 8'hFF, 3'd7, 6'h3F, 8'h00, 1'b0, 1'b1);
    do_fetch("f11", ldi(2'd0, 8'h5A), 0, 6'h3F);
    finish_ldi("ldi_63");
    chk("wrap_pc", {10'h0, imem_addr}, 16'h00);
    rd_chk("wrap_r0", 2'd0, 8'h5A);

    // Delayed ack with a different word on the bus, and run dropping mid-instruction.
    do_fetch("f12", ldi(2'd2, 8'h77), 3, 6'd0);
    run = 1'b0;
    finish_ldi("ldi_dly");
    rd_chk("dly_r2", 2'd2, 8'h77);
    rd_chk("dly_r3", 2'd3, 8'h01);
    chk("idle_req", {15'h0, imem_req}, 16'h0);
    imem_ack  = 1'b1;
    imem_data = ldi(2'd0, 8'h33);
    @(negedge CLK);
    imem_ack  = 1'b0;
    imem_data = 16'h0;
    repeat (3) @(negedge CLK);
    chk("idle_req2", {15'h0, imem_req}, 16'h0);
    chk("idle_pc", {10'h0, imem_addr}, 16'h01);
    rd_chk("idle_r0", 2'd0, 8'h5A);

    // Reset during WAIT of an ADD, with a stray ack while reset is held.
    run = 1'b1;
    do_fetch("f13", enc(3'd1, 2'd3, 2'd1, 2'd2, 6'd0), 0, 6'd1);
    @(negedge CLK);
    alu_result = 8'h99;
    @(negedge CLK);
    chk("pre_rst_op", {13'h0, alu_op}, 16'h1);
    RST = 1'b1;
    @(negedge CLK);
    chk("wrst_req", {15'h0, imem_req}, 16'h0);
    chk("wrst_pc", {10'h0, imem_addr}, 16'h00);
    chk("wrst_op", {13'h0, alu_op}, 16'h0);
    chk("wrst_a", {8'h0, alu_a}, 16'h0);
    chk("wrst_ret", {15'h0, retired}, 16'h0);
    rd_chk("wrst_r3", 2'd3, 8'h00);
    imem_ack  = 1'b1;
    imem_data = ldi(2'd1, 8'h44);
    @(negedge CLK);
    imem_ack  = 1'b0;
    imem_data = 16'h0;
    RST = 1'b0;
    @(negedge CLK);
    rd_chk("wrst_r1", 2'd1, 8'h00);
    do_fetch("f14", ldi(2'd1, 8'h44), 0, 6'd0);
    finish_ldi("ldi_post");
    rd_chk("post_r1", 2'd1, 8'h44);
    chk("post_pc", {10'h0, imem_addr}, 16'h01);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
